// File: rtl/stack_pkg.sv
// Shared types for the memory-backed stack sequencer: command opcodes and FSM states.
package stack_pkg;

   typedef enum logic [1:0] {
      OP_PUSH = 2'd0,
      OP_POP  = 2'd1,
      OP_CALL = 2'd2,
      OP_RET  = 2'd3
   } stack_op_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4,
      S_ERROR = 3'd5
   } stack_state_t;

endpackage

// File: rtl/stack_controller.sv
// Sequences PUSH/POP/CALL/RET onto a downward-growing memory stack, tracking depth,
// overflow/underflow and the PC load that CALL/RET imply.
module stack_controller
   import stack_pkg::*;
#(
   parameter logic [7:0] STACK_BASE = 8'hFF,
   parameter int         DEPTH      = 16
) (
   input  logic       clk,
   input  logic       reset,
   // Handshake: a command is taken on any rising edge where cmd_valid && cmd_ready;
   // cmd_ready is high only in IDLE, and operands are sampled on that same edge.
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] push_data,
   input  logic [7:0] pc_in,
   input  logic [7:0] call_target,
   output logic [7:0] mem_addr,
   output logic       mem_we,
   output logic       mem_re,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata,
   output logic [7:0] sp_out,
   output logic [7:0] pop_data,
   output logic       pc_load,
   output logic [7:0] pc_load_val,
   output logic       done,
   output logic       err,
   output logic       overflow,
   output logic       underflow,
   input  logic       err_clr,
   output logic [2:0] dbg_state
);

   localparam logic [7:0] DEPTH_C = 8'(DEPTH);

   stack_state_t state, state_next;
   stack_op_t    op_q;
   stack_op_t    op_in;
   logic [7:0]   count;
   logic [7:0]   wdata_q;
   logic [7:0]   target_q;
   logic [7:0]   result_q;
   logic         accept;
   logic         op_in_wr;
   logic         set_ovf;
   logic         set_unf;

   assign op_in    = stack_op_t'(cmd_op);
   assign accept   = cmd_valid && (state == S_IDLE);
   assign op_in_wr = (op_in == OP_PUSH) || (op_in == OP_CALL);
   assign set_ovf  = accept && op_in_wr && (count == DEPTH_C);
   assign set_unf  = accept && !op_in_wr && (count == 8'd0);

   assign sp_out    = STACK_BASE - count;
   assign dbg_state = state;

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (set_ovf || set_unf) state_next = S_ERROR;
            else if (accept)        state_next = op_in_wr ? S_WRITE : S_READ;
         end
         S_WRITE: state_next = S_DONE;
         S_READ:  state_next = S_WAIT;
         S_WAIT:  state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         S_ERROR: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // All outputs decode from registered state and latched operands only.
   always_comb begin
      cmd_ready   = 1'b0;
      mem_addr    = 8'd0;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      mem_wdata   = 8'd0;
      pc_load     = 1'b0;
      pc_load_val = 8'd0;
      done        = 1'b0;
      err         = 1'b0;
      case (state)
         S_IDLE: cmd_ready = 1'b1;
         S_WRITE: begin
            mem_we    = 1'b1;
            mem_addr  = STACK_BASE - count;
            mem_wdata = wdata_q;
         end
         S_READ: begin
            mem_re   = 1'b1;
            mem_addr = STACK_BASE - count + 8'd1;
         end
         S_DONE: begin
            done = 1'b1;
            if (op_q == OP_CALL) begin
               pc_load     = 1'b1;
               pc_load_val = target_q;
            end else if (op_q == OP_RET) begin
               pc_load     = 1'b1;
               pc_load_val = result_q;
            end
         end
         S_ERROR: begin
            done = 1'b1;
            err  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         op_q      <= OP_PUSH;
         count     <= 8'd0;
         wdata_q   <= 8'd0;
         target_q  <= 8'd0;
         result_q  <= 8'd0;
         pop_data  <= 8'd0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            op_q     <= op_in;
            wdata_q  <= (op_in == OP_CALL) ? pc_in : push_data;
            target_q <= call_target;
         end
         if (state == S_WRITE) count <= count + 8'd1;
         if (state == S_READ)  count <= count - 8'd1;
         if (state == S_WAIT) begin
            result_q <= mem_rdata;
            if (op_q == OP_POP) pop_data <= mem_rdata;
         end
         // A flag being set this cycle beats a simultaneous clear.
         overflow  <= set_ovf || (overflow && !err_clr);
         underflow <= set_unf || (underflow && !err_clr);
      end
   end

endmodule

// File: tb/tb_stack_controller.sv
// Self-checking bench for stack_controller: directed scenarios plus a randomized run
// compared against a queue-based stack model and a behavioural memory.
module tb_stack_controller;
   import stack_pkg::*;

   localparam logic [7:0] BASE  = 8'hFF;
   localparam int         DEPTH = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid, cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] push_data, pc_in, call_target;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_we, mem_re;
   logic [7:0] sp_out, pop_data, pc_load_val;
   logic       pc_load, done, err, overflow, underflow, err_clr;
   logic [2:0] dbg_state;

   int checks = 0;
   int errors = 0;

   stack_controller #(.STACK_BASE(BASE), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .push_data(push_data), .pc_in(pc_in), .call_target(call_target),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .sp_out(sp_out), .pop_data(pop_data),
      .pc_load(pc_load), .pc_load_val(pc_load_val),
      .done(done), .err(err), .overflow(overflow), .underflow(underflow),
      .err_clr(err_clr), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Behavioural stack memory with one-cycle read latency.
   logic [7:0] mem [256];
   initial mem_rdata = 8'd0;
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   // Reference model: the stack is a queue, top at the back.
   logic [7:0] model_q[$];
   bit         ovf_m, unf_m;
   logic [7:0] pop_m;
   int         e_lat, e_we_n, e_re_n, e_pcl_n;
   bit         e_err;
   logic [7:0] e_we_addr, e_we_data, e_re_addr, e_pcl_val, e_sp;

   // Observations from the last command.
   int         o_lat, o_we_n, o_re_n, o_pcl_n, o_pcl_cyc, o_ready_busy;
   bit         o_err, o_after_ready, o_after_done;
   logic [7:0] o_we_addr, o_we_data, o_re_addr, o_pcl_val, o_sp_done, o_pop_done;

   task automatic model_cmd(input stack_op_t op, input logic [7:0] d, input logic [7:0] pc,
                            input logic [7:0] tgt, input bit clr);
      bit wr;
      logic [7:0] v;
      wr = (op == OP_PUSH) || (op == OP_CALL);
      e_err = 0; e_we_n = 0; e_re_n = 0; e_pcl_n = 0; e_pcl_val = 8'd0;
      if (clr) begin ovf_m = 0; unf_m = 0; end
      if (wr && model_q.size() == DEPTH) begin
         e_err = 1; e_lat = 1; ovf_m = 1;
      end else if (!wr && model_q.size() == 0) begin
         e_err = 1; e_lat = 1; unf_m = 1;
      end else if (wr) begin
         e_lat = 2; e_we_n = 1;
         e_we_addr = BASE - 8'(model_q.size());
         e_we_data = (op == OP_CALL) ? pc : d;
         model_q.push_back(e_we_data);
         if (op == OP_CALL) begin e_pcl_n = 1; e_pcl_val = tgt; end
      end else begin
         e_lat = 3; e_re_n = 1;
         e_re_addr = BASE - 8'(model_q.size()) + 8'd1;
         v = model_q.pop_back();
         if (op == OP_POP) pop_m = v;
         else begin e_pcl_n = 1; e_pcl_val = v; end
      end
      e_sp = BASE - 8'(model_q.size());
   endtask

   // Drives one command and records what the DUT does until done (bounded).
   task automatic run_cmd(input stack_op_t op, input logic [7:0] d, input logic [7:0] pc,
                          input logic [7:0] tgt, input bit clr);
      int guard = 0;
      while (!cmd_ready && guard < 50) begin @(posedge clk); #1; guard++; end
      o_lat = 0; o_err = 0; o_we_n = 0; o_re_n = 0; o_pcl_n = 0; o_pcl_cyc = 0;
      o_ready_busy = 0; o_we_addr = 0; o_we_data = 0; o_re_addr = 0; o_pcl_val = 0;
      o_sp_done = 0; o_pop_done = 0;
      cmd_valid = 1'b1; cmd_op = op; push_data = d; pc_in = pc; call_target = tgt;
      err_clr = clr;
      @(posedge clk); #1;
      cmd_valid = 1'b0; err_clr = 1'b0;
      push_data = 8'($urandom); pc_in = 8'($urandom); call_target = 8'($urandom);
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) begin @(posedge clk); #1; end
         if (mem_we)  begin o_we_n++; o_we_addr = mem_addr; o_we_data = mem_wdata; end
         if (mem_re)  begin o_re_n++; o_re_addr = mem_addr; end
         if (pc_load) begin o_pcl_n++; o_pcl_val = pc_load_val; o_pcl_cyc = c; end
         if (cmd_ready) o_ready_busy++;
         if (done) begin
            o_lat = c; o_err = err; o_sp_done = sp_out; o_pop_done = pop_data;
            break;
         end
      end
      @(posedge clk); #1;
      o_after_ready = cmd_ready;
      o_after_done  = done;
   endtask

   task automatic pulse_err_clr();
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      ovf_m = 0; unf_m = 0;
   endtask

   task automatic test_reset();
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
      checks++; if (sp_out !== BASE) begin errors++; $display("FAIL reset_sp got %h exp %h", sp_out, BASE); end
      checks++; if (pop_data !== 8'd0) begin errors++; $display("FAIL reset_pop_data got %h exp 00", pop_data); end
      checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {overflow, underflow}); end
      checks++; if ({mem_we, mem_re, pc_load, done, err} !== 5'b0) begin errors++; $display("FAIL reset_strobes got %b exp 00000", {mem_we, mem_re, pc_load, done, err}); end
   endtask

   task automatic test_push_pop();
      logic [7:0] vals [3];
      logic [7:0] addrs [3];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
      addrs[0] = 8'hFF; addrs[1] = 8'hFE; addrs[2] = 8'hFD;
      for (int i = 0; i < 3; i++) begin
         model_cmd(OP_PUSH, vals[i], 8'h00, 8'h00, 0);
         run_cmd(OP_PUSH, vals[i], 8'h00, 8'h00, 0);
         checks++; if (o_we_n !== 1 || o_we_addr !== addrs[i] || o_we_data !== vals[i]) begin errors++; $display("FAIL push_write n=%0d addr=%h data=%h exp addr=%h data=%h", o_we_n, o_we_addr, o_we_data, addrs[i], vals[i]); end
         checks++; if (o_lat !== 2) begin errors++; $display("FAIL push_latency got %0d exp 2", o_lat); end
      end
      checks++; if (sp_out !== 8'hFC) begin errors++; $display("FAIL push_sp got %h exp FC", sp_out); end
      for (int i = 2; i >= 0; i--) begin
         model_cmd(OP_POP, 8'h00, 8'h00, 8'h00, 0);
         run_cmd(OP_POP, 8'h00, 8'h00, 8'h00, 0);
         checks++; if (o_pop_done !== vals[i] || o_re_addr !== addrs[i]) begin errors++; $display("FAIL pop_data got %h @%h exp %h @%h", o_pop_done, o_re_addr, vals[i], addrs[i]); end
         checks++; if (o_lat !== 3 || o_we_n !== 0) begin errors++; $display("FAIL pop_timing lat=%0d we=%0d exp lat=3 we=0", o_lat, o_we_n); end
      end
      checks++; if (sp_out !== 8'hFF) begin errors++; $display("FAIL pop_sp got %h exp FF", sp_out); end
   endtask

   task automatic test_call_ret();
      model_cmd(OP_CALL, 8'h00, 8'h40, 8'h80, 0);
      run_cmd(OP_CALL, 8'h00, 8'h40, 8'h80, 0);
      checks++; if (o_we_addr !== 8'hFF || o_we_data !== 8'h40) begin errors++; $display("FAIL call_write got %h@%h exp 40@FF", o_we_data, o_we_addr); end
      checks++; if (o_pcl_n !== 1 || o_pcl_val !== 8'h80 || o_pcl_cyc !== 2) begin errors++; $display("FAIL call_pc_load n=%0d val=%h cyc=%0d exp 1 80 2", o_pcl_n, o_pcl_val, o_pcl_cyc); end
      model_cmd(OP_RET, 8'h00, 8'h00, 8'h00, 0);
      run_cmd(OP_RET, 8'h00, 8'h00, 8'h00, 0);
      checks++; if (o_re_n !== 1 || o_re_addr !== 8'hFF) begin errors++; $display("FAIL ret_read n=%0d addr=%h exp 1 FF", o_re_n, o_re_addr); end
      checks++; if (o_pcl_n !== 1 || o_pcl_val !== 8'h40 || o_pcl_cyc !== 3) begin errors++; $display("FAIL ret_pc_load n=%0d val=%h cyc=%0d exp 1 40 3", o_pcl_n, o_pcl_val, o_pcl_cyc); end
      checks++; if (pop_data !== 8'h11) begin errors++; $display("FAIL ret_keeps_pop_data got %h exp 11", pop_data); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < DEPTH; i++) begin
         model_cmd(OP_PUSH, 8'(i + 8'hA0), 8'h00, 8'h00, 0);
         run_cmd(OP_PUSH, 8'(i + 8'hA0), 8'h00, 8'h00, 0);
      end
      checks++; if (sp_out !== 8'hEF) begin errors++; $display("FAIL full_sp got %h exp EF", sp_out); end
      model_cmd(OP_PUSH, 8'h99, 8'h00, 8'h00, 0);
      run_cmd(OP_PUSH, 8'h99, 8'h00, 8'h00, 0);
      checks++; if (o_err !== 1'b1 || o_lat !== 1 || o_we_n !== 0) begin errors++; $display("FAIL ovf_cmd err=%b lat=%0d we=%0d exp 1 1 0", o_err, o_lat, o_we_n); end
      checks++; if (overflow !== 1'b1 || sp_out !== 8'hEF) begin errors++; $display("FAIL ovf_flag ovf=%b sp=%h exp 1 EF", overflow, sp_out); end
      pulse_err_clr();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
      for (int i = 0; i < DEPTH; i++) begin
         model_cmd(OP_POP, 8'h00, 8'h00, 8'h00, 0);
         run_cmd(OP_POP, 8'h00, 8'h00, 8'h00, 0);
         checks++; if (o_pop_done !== pop_m || o_err !== 1'b0) begin errors++; $display("FAIL drain_pop got %h err=%b exp %h", o_pop_done, o_err, pop_m); end
      end
   endtask

   task automatic test_underflow();
      model_cmd(OP_POP, 8'h00, 8'h00, 8'h00, 0);
      run_cmd(OP_POP, 8'h00, 8'h00, 8'h00, 0);
      checks++; if (o_err !== 1'b1 || o_lat !== 1 || o_re_n !== 0) begin errors++; $display("FAIL unf_cmd err=%b lat=%0d re=%0d exp 1 1 0", o_err, o_lat, o_re_n); end
      checks++; if (underflow !== 1'b1 || sp_out !== BASE) begin errors++; $display("FAIL unf_flag unf=%b sp=%h exp 1 FF", underflow, sp_out); end
      pulse_err_clr();
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clear got %b exp 0", underflow); end
      // err_clr asserted on the very edge that sets the flag: the set must win.
      model_cmd(OP_RET, 8'h00, 8'h00, 8'h00, 1);
      run_cmd(OP_RET, 8'h00, 8'h00, 8'h00, 1);
      checks++; if (underflow !== 1'b1 || o_pcl_n !== 0) begin errors++; $display("FAIL set_beats_clear unf=%b pcl=%0d exp 1 0", underflow, o_pcl_n); end
      pulse_err_clr();
   endtask

   task automatic test_reset_mid_pop();
      model_cmd(OP_PUSH, 8'h5A, 8'h00, 8'h00, 0);
      run_cmd(OP_PUSH, 8'h5A, 8'h00, 8'h00, 0);
      cmd_valid = 1'b1; cmd_op = OP_POP;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL mid_read_active got %b exp 1", mem_re); end
      reset = 1'b1;
      #1;
      checks++; if (mem_re !== 1'b0 || sp_out !== BASE || cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_reset re=%b sp=%h rdy=%b exp 0 FF 1", mem_re, sp_out, cmd_ready); end
      model_q.delete(); ovf_m = 0; unf_m = 0; pop_m = 8'd0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      checks++; if (cmd_ready !== 1'b1 || pop_data !== 8'd0 || mem_re !== 1'b0) begin errors++; $display("FAIL after_reset rdy=%b pop=%h re=%b exp 1 00 0", cmd_ready, pop_data, mem_re); end
   endtask

   task automatic test_random();
      stack_op_t  op;
      logic [7:0] d, pc, tgt;
      bit         clr;
      for (int n = 0; n < 120; n++) begin
         op  = stack_op_t'($urandom_range(0, 3));
         d   = 8'($urandom); pc = 8'($urandom); tgt = 8'($urandom);
         clr = ($urandom_range(0, 7) == 0);
         model_cmd(op, d, pc, tgt, clr);
         run_cmd(op, d, pc, tgt, clr);
         checks++; if (o_lat !== e_lat || o_err !== e_err) begin errors++; $display("FAIL rnd_done op=%0d lat=%0d err=%b exp %0d %b", op, o_lat, o_err, e_lat, e_err); end
         checks++; if (o_we_n !== e_we_n || (e_we_n == 1 && (o_we_addr !== e_we_addr || o_we_data !== e_we_data))) begin errors++; $display("FAIL rnd_write op=%0d n=%0d %h@%h exp n=%0d %h@%h", op, o_we_n, o_we_data, o_we_addr, e_we_n, e_we_data, e_we_addr); end
         checks++; if (o_re_n !== e_re_n || (e_re_n == 1 && o_re_addr !== e_re_addr)) begin errors++; $display("FAIL rnd_read op=%0d n=%0d @%h exp n=%0d @%h", op, o_re_n, o_re_addr, e_re_n, e_re_addr); end
         checks++; if (o_pcl_n !== e_pcl_n || o_pcl_val !== e_pcl_val) begin errors++; $display("FAIL rnd_pc_load op=%0d n=%0d val=%h exp n=%0d val=%h", op, o_pcl_n, o_pcl_val, e_pcl_n, e_pcl_val); end
         checks++; if (o_sp_done !== e_sp || o_pop_done !== pop_m) begin errors++; $display("FAIL rnd_state sp=%h pop=%h exp sp=%h pop=%h", o_sp_done, o_pop_done, e_sp, pop_m); end
         checks++; if (overflow !== ovf_m || underflow !== unf_m) begin errors++; $display("FAIL rnd_flags ovf=%b unf=%b exp %b %b", overflow, underflow, ovf_m, unf_m); end
         checks++; if (o_ready_busy !== 0 || o_after_ready !== 1'b1 || o_after_done !== 1'b0) begin errors++; $display("FAIL rnd_handshake busy_rdy=%0d rdy=%b done=%b exp 0 1 0", o_ready_busy, o_after_ready, o_after_done); end
      end
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; push_data = 8'd0; pc_in = 8'd0;
      call_target = 8'd0; err_clr = 1'b0;
      ovf_m = 0; unf_m = 0; pop_m = 8'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_push_pop();
      test_call_ret();
      test_overflow();
      test_underflow();
      test_reset_mid_pop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stack_controller.md
# stack_controller

Sequencer for the CPU's memory-backed stack. Accepts PUSH/POP/CALL/RET commands from the control unit over a valid/ready handshake and drives the stack memory port, stack pointer value and program-counter load. It owns stack depth and overflow/underflow detection, so the control unit issues one command per stack instruction and waits for `done`.

## Interface
- `STACK_BASE`, 8'hFF: address of the first stack slot; the stack grows downward.
- `DEPTH`, 16: maximum number of entries, 1..255.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: controller idle; a command is accepted when valid && ready.
- `cmd_op` in 2: 0 PUSH, 1 POP, 2 CALL, 3 RET.
- `push_data` in 8: PUSH operand, sampled at accept.
- `pc_in` in 8: return address for CALL, sampled at accept.
- `call_target` in 8: CALL destination, sampled at accept.
- `mem_addr` out 8: stack memory address.
- `mem_we` out 1: memory write strobe, one cycle.
- `mem_re` out 1: memory read strobe; data returns on `mem_rdata` the next cycle.
- `mem_wdata` out 8: write data.
- `mem_rdata` in 8: read data.
- `sp_out` out 8: current stack pointer, equal to STACK_BASE − count (next free slot).
- `pop_data` out 8: POP result; holds until the next POP completes.
- `pc_load` out 1: one-cycle PC write strobe.
- `pc_load_val` out 8: PC value that accompanies `pc_load`.
- `done` out 1: one-cycle completion pulse, including error completions.
- `err` out 1: qualifies `done`; the command was rejected.
- `overflow`, `underflow` out 1: sticky error flags.
- `err_clr` in 1: clears both sticky flags.

## Operation
- Internal state: `count` (0..DEPTH), an op/operand latch and the FSM state.
- FSM states: IDLE, WRITE, READ, WAIT, DONE, ERROR.
- IDLE
  - `cmd_ready`=1.
  - On accept, latch op and operands, then branch:
    - PUSH or CALL with count==DEPTH → ERROR, set `overflow`.
    - POP or RET with count==0 → ERROR, set `underflow`.
    - Otherwise PUSH/CALL → WRITE; POP/RET → READ.
- WRITE
  - `mem_we`=1, `mem_addr`=STACK_BASE−count.
  - `mem_wdata` = `push_data` (PUSH) or `pc_in` (CALL), taken from the latch.
  - count+1 at the edge, then → DONE.
- READ
  - `mem_re`=1, `mem_addr`=STACK_BASE−count+1.
  - count−1 at the edge, then → WAIT.
- WAIT: capture `mem_rdata` into the result register, then → DONE.
- DONE
  - `done`=1.
  - POP: `pop_data` updates at the WAIT→DONE edge.
  - CALL: `pc_load`=1, `pc_load_val`=latched `call_target`.
  - RET: `pc_load`=1, `pc_load_val`=captured result.
  - → IDLE.
- ERROR
  - `done`=1, `err`=1, no memory strobe, count unchanged, `pc_load`=0.
  - → IDLE.
- Address arithmetic is 8-bit modulo 256. With legal DEPTH no wrap occurs; the depth check prevents wrap.
- `err_clr` in the same cycle a flag sets: set wins.
- `cmd_valid` while `cmd_ready`=0 is ignored. Commands are not queued.

## Timing
- Reset values:
  - State IDLE, count 0, `sp_out`=STACK_BASE, `pop_data`=0.
  - Flags 0; all strobes 0; `cmd_ready`=1.
- Strobes and `mem_addr`/`mem_wdata`/`pc_load`/`done` decode from registered state only. No combinational path from inputs to outputs except none.
- Latency from the accept edge to `done` high:
  - PUSH, CALL: 2 cycles.
  - POP, RET: 3 cycles.
  - Errors: 1 cycle.
- `cmd_ready` returns high the cycle after `done`. Back-to-back throughput is one command per 3 (PUSH) or 4 (POP) cycles.
- `sp_out` changes on the edge that leaves WRITE/READ; the new value is visible in DONE/WAIT.
- Reset asserted mid-command: outputs drop immediately (asynchronous), and a partial write is not re-issued. The stack contents are lost logically (count=0).

## Structure
- Package `stack_pkg`:
  - `stack_op_t` enum (PUSH/POP/CALL/RET).
  - `stack_state_t` enum (the six states).
- Single module with an inline depth counter. No sub-module. The generic counter is not reused because the up/down depth check is needed in the same cycle.

## Test plan
- 3× PUSH of 8'h11/22/33 → writes at FF, FE, FD; `sp_out`=FC.
- Then 3× POP with memory returning the written values → `pop_data` 33, 22, 11; `sp_out`=FF.
- CALL with pc_in=8'h40, target=8'h80 → write 40 @FF; `pc_load` with 80 exactly 2 cycles after accept.
- Then RET → read @FF, `pc_load` with 40 exactly 3 cycles after accept.
- DEPTH=16: the 17th PUSH gives `done`+`err`, `overflow`=1, no `mem_we`, `sp_out` stays EF.
- POP on empty stack → `underflow`=1. Then `err_clr` clears it.
- Reset during READ of a POP → `mem_re` drops in the same cycle, `sp_out`=FF, `cmd_ready`=1 after release.
